// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: FSM states,
// dark-display constants and the active-low hex-to-segment table.
package seg_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShow  = 2'd1,
        StBlank = 2'd2
    } state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // {g,f,e,d,c,b,a}, active-low, indexed by nibble value
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Application-side and pin-side signals of the scan controller.
// The master drives data/enables; the slave (controller) drives the display pins.
interface seg_scan_ctrl_if;

    logic        i_en;
    logic [31:0] i_data;
    logic [7:0]  i_dp;
    logic [7:0]  i_dig_mask;
    logic [7:0]  o_an;
    logic [6:0]  o_seg;
    logic        o_dpo;
    logic [2:0]  o_num;
    logic        o_frame_tick;

    modport master (
        output i_en, i_data, i_dp, i_dig_mask,
        input  o_an, o_seg, o_dpo, o_num, o_frame_tick
    );

    modport slave (
        input  i_en, i_data, i_dp, i_dig_mask,
        output o_an, o_seg, o_dpo, o_num, o_frame_tick
    );

endinterface

// File: rtl/seg_scan_ctrl_hex_to_seg7.sv
// Combinational nibble to active-low seven-segment pattern decoder.
module hex_to_seg7
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = HEX_SEG[i_nibble];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit common-anode scan controller with inter-digit blanking and
// frame-boundary shadow capture so a displayed frame never tears.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CNT   = 100000,
    parameter int unsigned BLANK_CYC = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    seg_scan_ctrl_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(max_u(DIV_CNT, BLANK_CYC));
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV_CNT - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_num;
    logic [31:0]      r_data;
    logic [7:0]       r_dp;
    logic [7:0]       r_mask;
    logic [7:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dpo;
    logic             r_tick;

    state_e           w_state_d;
    logic [CNT_W-1:0] w_cnt_d;
    logic [2:0]       w_num_d;
    logic [31:0]      w_data_d;
    logic [7:0]       w_dp_d;
    logic [7:0]       w_mask_d;
    logic             w_tick_d;
    logic [3:0]       w_nibble_d;
    logic [6:0]       w_seg_dec;
    logic             w_show_d;
    logic [7:0]       w_an_d;
    logic [6:0]       w_seg_d;
    logic             w_dpo_d;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_num_d   = r_num;
        w_data_d  = r_data;
        w_dp_d    = r_dp;
        w_mask_d  = r_mask;
        w_tick_d  = 1'b0;

        // Dropping the enable beats everything, including a pending wrap.
        if (!bus.i_en) begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
            w_num_d   = 3'd0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    w_state_d = StShow;
                    w_cnt_d   = '0;
                    w_num_d   = 3'd0;
                    w_data_d  = bus.i_data;
                    w_dp_d    = bus.i_dp;
                    w_mask_d  = bus.i_dig_mask;
                end
                StShow: begin
                    if (r_cnt == DIV_LAST) begin
                        w_state_d = StBlank;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = r_cnt + CNT_W'(1);
                    end
                end
                StBlank: begin
                    if (r_cnt == BLANK_LAST) begin
                        w_state_d = StShow;
                        w_cnt_d   = '0;
                        w_num_d   = r_num + 3'd1;
                        if (r_num == 3'd7) begin
                            w_data_d = bus.i_data;
                            w_dp_d   = bus.i_dp;
                            w_mask_d = bus.i_dig_mask;
                            w_tick_d = 1'b1;
                        end
                    end else begin
                        w_cnt_d = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                    w_num_d   = 3'd0;
                end
            endcase
        end
    end

    // Outputs are derived from next-state values so every pin moves on one edge.
    assign w_nibble_d = w_data_d[{w_num_d, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .i_nibble (w_nibble_d),
        .o_seg    (w_seg_dec)
    );

    always_comb begin
        w_show_d = (w_state_d == StShow);
        w_an_d   = AN_OFF;
        w_seg_d  = SEG_OFF;
        w_dpo_d  = 1'b1;
        if (w_show_d) begin
            if (w_mask_d[w_num_d]) begin
                w_an_d = ~(8'b1 << w_num_d);
            end
            w_seg_d = w_seg_dec;
            w_dpo_d = ~w_dp_d[w_num_d];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_num   <= 3'd0;
            r_data  <= 32'd0;
            r_dp    <= 8'd0;
            r_mask  <= 8'd0;
            r_an    <= AN_OFF;
            r_seg   <= SEG_OFF;
            r_dpo   <= 1'b1;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_num   <= w_num_d;
            r_data  <= w_data_d;
            r_dp    <= w_dp_d;
            r_mask  <= w_mask_d;
            r_an    <= w_an_d;
            r_seg   <= w_seg_d;
            r_dpo   <= w_dpo_d;
            r_tick  <= w_tick_d;
        end
    end

    assign bus.o_an         = r_an;
    assign bus.o_seg        = r_seg;
    assign bus.o_dpo        = r_dpo;
    assign bus.o_num        = r_num;
    assign bus.o_frame_tick = r_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: a frame-timeline model checked every
// cycle, plus directed literal checks for reset, masking, tearing, EN and reset.
module tb_seg_scan_ctrl;

    localparam int unsigned DIV   = 4;
    localparam int unsigned BLK   = 2;
    localparam int unsigned P     = DIV + BLK;
    localparam int unsigned FRAME = 8 * P;

    localparam logic [6:0] HEX_TB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(
        .DIV_CNT   (DIV),
        .BLANK_CYC (BLK)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: position within the scan timeline since the first lit cycle.
    logic        m_run;
    int unsigned m_t;
    logic [31:0] m_data;
    logic [7:0]  m_dp;
    logic [7:0]  m_mask;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run  <= 1'b0;
            m_t    <= 0;
            m_data <= 32'd0;
            m_dp   <= 8'd0;
            m_mask <= 8'd0;
        end else if (!bus.i_en) begin
            m_run <= 1'b0;
            m_t   <= 0;
        end else if (!m_run) begin
            m_run  <= 1'b1;
            m_t    <= 0;
            m_data <= bus.i_data;
            m_dp   <= bus.i_dp;
            m_mask <= bus.i_dig_mask;
        end else begin
            m_t <= m_t + 1;
            if ((m_t + 1) % FRAME == 0) begin
                m_data <= bus.i_data;
                m_dp   <= bus.i_dp;
                m_mask <= bus.i_dig_mask;
            end
        end
    end

    int unsigned slot;
    int unsigned ph;
    logic        lit;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dpo;
    logic [2:0]  e_num;
    logic        e_tick;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            slot   = (m_t / P) % 8;
            ph     = m_t % P;
            lit    = m_run && (ph < DIV);
            e_num  = m_run ? slot[2:0] : 3'd0;
            e_an   = (lit && m_mask[slot]) ? ~(8'b1 << slot) : 8'hFF;
            e_seg  = lit ? HEX_TB[m_data[slot*4 +: 4]] : 7'h7F;
            e_dpo  = lit ? ~m_dp[slot] : 1'b1;
            e_tick = m_run && (m_t > 0) && (m_t % FRAME == 0);
            check("cyc_an",   {24'd0, bus.o_an},   {24'd0, e_an});
            check("cyc_seg",  {25'd0, bus.o_seg},  {25'd0, e_seg});
            check("cyc_dpo",  {31'd0, bus.o_dpo},  {31'd0, e_dpo});
            check("cyc_num",  {29'd0, bus.o_num},  {29'd0, e_num});
            check("cyc_tick", {31'd0, bus.o_frame_tick}, {31'd0, e_tick});
        end
    end

    // kind 0: digit k lit, 1: blank gap after digit k, 2: frame tick, 3: NUM==k
    task automatic wait_until(input int kind, input logic [2:0] k, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            case (kind)
                0: ok = (bus.o_num == k) && (bus.o_an != 8'hFF);
                1: ok = (bus.o_num == k) && (bus.o_an == 8'hFF) && (bus.o_seg == 7'h7F);
                2: ok = bus.o_frame_tick;
                default: ok = (bus.o_num == k);
            endcase
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_%s: got timeout expected event", nm);
        end
    endtask

    int t0;

    initial begin
        rst_n           = 1'b0;
        bus.i_en        = 1'b1;
        bus.i_data      = 32'h76543210;
        bus.i_dp        = 8'h00;
        bus.i_dig_mask  = 8'hFF;

        #12;
        check("rst_an",   {24'd0, bus.o_an}, 32'hFF);
        check("rst_seg",  {25'd0, bus.o_seg}, 32'h7F);
        check("rst_dpo",  {31'd0, bus.o_dpo}, 32'h1);
        check("rst_num",  {29'd0, bus.o_num}, 32'h0);
        check("rst_tick", {31'd0, bus.o_frame_tick}, 32'h0);
        rst_n = 1'b1;

        // First edge with EN high lights digit 0.
        @(negedge clk);
        check("d0_an",  {24'd0, bus.o_an}, 32'hFE);
        check("d0_seg", {25'd0, bus.o_seg}, 32'h40);
        repeat (3) @(negedge clk);
        check("d0_last_lit", {24'd0, bus.o_an}, 32'hFE);
        @(negedge clk);
        check("d0_blank", {24'd0, bus.o_an}, 32'hFF);
        repeat (2) @(negedge clk);
        check("d1_an",  {24'd0, bus.o_an}, 32'hFD);
        check("d1_seg", {25'd0, bus.o_seg}, 32'h79);

        wait_until(0, 3'd7, "d7");
        check("d7_an",  {24'd0, bus.o_an}, 32'h7F);
        check("d7_seg", {25'd0, bus.o_seg}, 32'h78);

        wait_until(2, 3'd0, "tick_a");
        t0 = cyc;
        wait_until(2, 3'd0, "tick_b");
        check("frame_period", cyc - t0, FRAME);

        // Mask/DP changes take effect only at the next wrap.
        #1;
        bus.i_dig_mask = 8'h0F;
        bus.i_dp       = 8'h01;
        wait_until(2, 3'd0, "tick_mask");
        check("mask_d0_an",  {24'd0, bus.o_an}, 32'hFE);
        check("mask_d0_dpo", {31'd0, bus.o_dpo}, 32'h0);
        wait_until(3, 3'd5, "num5");
        check("mask_d5_an", {24'd0, bus.o_an}, 32'hFF);
        wait_until(2, 3'd0, "tick_mc");
        t0 = cyc;
        wait_until(2, 3'd0, "tick_md");
        check("mask_frame_period", cyc - t0, FRAME);
        #1;
        bus.i_dig_mask = 8'hFF;
        bus.i_dp       = 8'h00;
        wait_until(2, 3'd0, "tick_unmask");

        // Tear-free update.
        wait_until(0, 3'd3, "tear_d3");
        #1;
        bus.i_data = 32'hFFFF_FFFF;
        wait_until(0, 3'd7, "tear_d7");
        check("tear_d7_old", {25'd0, bus.o_seg}, 32'h78);
        wait_until(2, 3'd0, "tear_tick");
        check("tear_d0_new", {25'd0, bus.o_seg}, 32'h0E);
        check("tear_d0_an",  {24'd0, bus.o_an}, 32'hFE);
        #1;
        bus.i_data = 32'h76543210;

        // EN drop mid-SHOW.
        wait_until(0, 3'd5, "en_d5");
        #1;
        bus.i_en = 1'b0;
        @(negedge clk);
        check("en_off_an",   {24'd0, bus.o_an}, 32'hFF);
        check("en_off_num",  {29'd0, bus.o_num}, 32'h0);
        check("en_off_tick", {31'd0, bus.o_frame_tick}, 32'h0);
        check("en_off_seg",  {25'd0, bus.o_seg}, 32'h7F);
        #1;
        bus.i_en = 1'b1;
        @(negedge clk);
        check("en_on_an",  {24'd0, bus.o_an}, 32'hFE);
        check("en_on_seg", {25'd0, bus.o_seg}, 32'h40);

        // Asynchronous reset in the middle of a blank gap.
        wait_until(1, 3'd2, "blank2");
        @(posedge clk);
        #2;
        check("pre_rst_num", {29'd0, bus.o_num}, 32'h2);
        rst_n = 1'b0;
        #1;
        check("arst_an",   {24'd0, bus.o_an}, 32'hFF);
        check("arst_seg",  {25'd0, bus.o_seg}, 32'h7F);
        check("arst_dpo",  {31'd0, bus.o_dpo}, 32'h1);
        check("arst_num",  {29'd0, bus.o_num}, 32'h0);
        check("arst_tick", {31'd0, bus.o_frame_tick}, 32'h0);
        #3;
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
